// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stage events in, register controls out.
// The master side raises the events and the slave side is the control unit.
interface pipe_ctrl_if;
  logic       i_load_use;
  logic       i_imem_wait;
  logic       i_dmem_wait;
  logic       i_br_mispred;
  logic       i_mc_start;
  logic       i_mc_done;
  logic       i_trap;
  logic       o_pc_en;
  logic [1:0] o_pc_sel;
  logic [3:0] o_en;
  logic [3:0] o_srsh;
  logic       o_mc_kill;
  logic       o_mc_tmo;
  logic       o_busy;

  modport master (
    output i_load_use, i_imem_wait, i_dmem_wait,
    output i_br_mispred, i_mc_start, i_mc_done,
    output i_trap,
    input  o_pc_en, o_pc_sel, o_en, o_srsh,
    input  o_mc_kill, o_mc_tmo, o_busy
  );

  modport slave (
    input  i_load_use, i_imem_wait, i_dmem_wait,
    input  i_br_mispred, i_mc_start, i_mc_done,
    input  i_trap,
    output o_pc_en, o_pc_sel, o_en, o_srsh,
    output o_mc_kill, o_mc_tmo, o_busy
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline control: resolves stall/flush/redirect events
// into per-register enable and synchronous-flush actions.
module pipe_ctrl #(
  parameter int MC_TMO = 64
) (
  input  logic      i_clk,
  input  logic      i_rst,
  pipe_ctrl_if.slave bus
);

  localparam int CW = $clog2(MC_TMO + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(MC_TMO);
  localparam logic [CW-1:0] TMO_M1  = CW'(MC_TMO - 1);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MCWAIT   = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       pc_en;
  logic [1:0] pc_sel;
  logic [3:0] en;
  logic [3:0] srsh;
  logic       mc_kill;
  logic       mc_tmo;

  always_comb begin
    pc_en   = 1'b1;
    pc_sel  = 2'b00;
    en      = 4'b1111;
    srsh    = 4'b0000;
    mc_kill = 1'b0;
    state_d = state_q;
    if (i_rst) begin
      pc_en   = 1'b0;
      en      = 4'b0000;
      srsh    = 4'b1111;
      state_d = RUN;
    end else if (bus.i_trap) begin
      srsh    = 4'b1111;
      pc_sel  = 2'b10;
      mc_kill = (state_q == MCWAIT);
      state_d = REDIRECT;
    end else if (bus.i_dmem_wait) begin
      pc_en = 1'b0;
      en    = 4'b0000;
    end else begin
      case (state_q)
        MCWAIT: begin
          if (bus.i_mc_done) begin
            state_d = RUN;
          end else begin
            pc_en = 1'b0;
            en    = 4'b1000;
            srsh  = 4'b0100;
          end
        end
        REDIRECT: begin
          srsh = 4'b0001;
          if (bus.i_imem_wait) begin
            pc_en = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          if (bus.i_br_mispred) begin
            srsh    = 4'b0011;
            pc_sel  = 2'b01;
            state_d = REDIRECT;
          end else if (bus.i_mc_start &&
                       !bus.i_mc_done) begin
            pc_en   = 1'b0;
            en      = 4'b1000;
            srsh    = 4'b0100;
            state_d = MCWAIT;
          end else if (bus.i_load_use) begin
            pc_en = 1'b0;
            en    = 4'b1110;
            srsh  = 4'b0010;
          end else if (bus.i_imem_wait) begin
            pc_en = 1'b0;
            srsh  = 4'b0001;
          end
        end
      endcase
    end
  end

  // Count of MCWAIT cycles elapsed; zero outside MCWAIT so entry starts clean.
  always_comb begin
    cnt_d = '0;
    if (state_q == MCWAIT) begin
      cnt_d = (cnt_q == TMO_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign mc_tmo = !i_rst && (state_q == MCWAIT) &&
                  (cnt_q == TMO_M1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_pc_en   = pc_en;
  assign bus.o_pc_sel  = pc_sel;
  assign bus.o_en      = en;
  assign bus.o_srsh    = srsh;
  assign bus.o_mc_kill = mc_kill;
  assign bus.o_mc_tmo  = mc_tmo;
  assign bus.o_busy    = !i_rst && (state_q != RUN);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl with MC_TMO=4.
// Each record is one cycle: inputs plus expected control outputs.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MC_TMO(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  localparam logic [7:0] IDLE = 8'h00;
  localparam logic [7:0] MCD  = 8'h01;
  localparam logic [7:0] MCS  = 8'h02;
  localparam logic [7:0] MIS  = 8'h04;
  localparam logic [7:0] LU   = 8'h08;
  localparam logic [7:0] IMW  = 8'h10;
  localparam logic [7:0] DMW  = 8'h20;
  localparam logic [7:0] TRP  = 8'h40;
  localparam logic [7:0] RST  = 8'h80;

  typedef struct {
    logic [7:0]  in;
    logic [13:0] exp;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  function automatic void add(
    logic [7:0] in, logic pe, logic [1:0] ps,
    logic [3:0] en, logic [3:0] sr,
    logic k, logic t, logic b);
    vec_t v;
    v.in  = in;
    v.exp = {pe, ps, en, sr, k, t, b};
    vq.push_back(v);
  endfunction

  task automatic drive(input logic [7:0] in);
    rst              = in[7];
    bus.i_trap       = in[6];
    bus.i_dmem_wait  = in[5];
    bus.i_imem_wait  = in[4];
    bus.i_load_use   = in[3];
    bus.i_br_mispred = in[2];
    bus.i_mc_start   = in[1];
    bus.i_mc_done    = in[0];
  endtask

  function automatic logic [13:0] got();
    return {bus.o_pc_en, bus.o_pc_sel, bus.o_en,
            bus.o_srsh, bus.o_mc_kill, bus.o_mc_tmo,
            bus.o_busy};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  initial begin
    int pulses;
    int first_at;
    drive(RST);

    // reset
    add(RST, 0, 2'b00, 4'b0000, 4'b1111, 0, 0, 0);
    add(RST, 0, 2'b00, 4'b0000, 4'b1111, 0, 0, 0);
    add(RST, 0, 2'b00, 4'b0000, 4'b1111, 0, 0, 0);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);
    // mispredict
    add(MIS, 1, 2'b01, 4'b1111, 4'b0011, 0, 0, 0);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0001, 0, 0, 1);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);
    // multi-cycle op, done on cycle 5
    add(MCS, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 0);
    add(MCS, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(MCS, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(MCS, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(MCS, 0, 2'b00, 4'b1000, 4'b0100, 0, 1, 1);
    add(MCS|MCD, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 1);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);
    // start and done together
    add(MCS|MCD, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);
    // load-use, imem wait
    add(LU, 0, 2'b00, 4'b1110, 4'b0010, 0, 0, 0);
    add(IMW, 0, 2'b00, 4'b1111, 4'b0001, 0, 0, 0);
    // trap in MCWAIT with dmem wait
    add(MCS, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 0);
    add(MCS, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(MCS|TRP|DMW, 1, 2'b10, 4'b1111, 4'b1111, 1, 0, 1);
    add(IMW, 0, 2'b00, 4'b1111, 4'b0001, 0, 0, 1);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0001, 0, 0, 1);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);
    // freeze priority
    add(DMW|MIS|LU, 0, 2'b00, 4'b0000, 4'b0000, 0, 0, 0);
    add(DMW|MIS|LU, 0, 2'b00, 4'b0000, 4'b0000, 0, 0, 0);
    add(MIS|LU, 1, 2'b01, 4'b1111, 4'b0011, 0, 0, 0);
    add(LU, 1, 2'b00, 4'b1111, 4'b0001, 0, 0, 1);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);
    // trap in RUN
    add(TRP|MIS, 1, 2'b10, 4'b1111, 4'b1111, 0, 0, 0);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0001, 0, 0, 1);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);
    // timeout, freeze, reset mid-MCWAIT
    add(MCS, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 0);
    add(IDLE, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(IDLE, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(IDLE, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(IDLE, 0, 2'b00, 4'b1000, 4'b0100, 0, 1, 1);
    add(IDLE, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(DMW, 0, 2'b00, 4'b0000, 4'b0000, 0, 0, 1);
    add(IDLE, 0, 2'b00, 4'b1000, 4'b0100, 0, 0, 1);
    add(RST, 0, 2'b00, 4'b0000, 4'b1111, 0, 0, 0);
    add(IDLE, 1, 2'b00, 4'b1111, 4'b0000, 0, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].in);
      #2;
      chk($sformatf("vec%0d", i), 32'(got()),
          32'(vq[i].exp));
    end

    // bounded scan: single timeout pulse on 4th MCWAIT cycle
    @(negedge clk);
    drive(MCS);
    pulses   = 0;
    first_at = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      drive(IDLE);
      #2;
      if (bus.o_mc_tmo) begin
        pulses++;
        if (first_at == 0) first_at = c;
      end
      chk($sformatf("scan_busy%0d", c),
          32'(bus.o_busy), 32'd1);
    end
    chk("tmo_pulses", 32'(pulses), 32'd1);
    chk("tmo_cycle", 32'(first_at), 32'd4);

    // asynchronous reset between edges
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_busy", 32'(bus.o_busy), 32'd0);
    chk("async_en", 32'(bus.o_en), 32'd0);
    chk("async_kill", 32'(bus.o_mc_kill), 32'd0);
    @(negedge clk);
    drive(IDLE);
    @(negedge clk);
    #2;
    chk("post_rst", 32'(got()),
        32'({1'b1, 2'b00, 4'b1111, 4'b0000,
             1'b0, 1'b0, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage core (IF, ID, EX, MEM, WB). It drives the enable and synchronous-flush inputs of the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Hazard, branch, trap, multi-cycle-unit and memory-wait events are resolved here into per-register hold, bubble or redirect actions. A small FSM sequences multi-cycle EX operations and the post-redirect cycle needed by the synchronous IMEM.

## Interface
- MC_TMO, 64, number of MCWAIT cycles before timeout pulse (>=2)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_load_use  in  1  ID instruction depends on load currently in EX
- i_imem_wait  in  1  instruction memory not ready
- i_dmem_wait  in  1  data memory not ready (MEM stage stalled)
- i_br_mispred  in  1  EX resolved a mispredicted branch/jump
- i_mc_start  in  1  EX holds a multi-cycle op (div) this cycle
- i_mc_done  in  1  multi-cycle unit result valid
- i_trap  in  1  MEM stage raises exception
- o_pc_en  out  1  PC register enable
- o_pc_sel  out  2  00 sequential, 01 branch target, 10 trap vector
- o_en  out  4  enables; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB
- o_srsh  out  4  synchronous flush, same bit mapping; flush overrides enable in the register
- o_mc_kill  out  1  abort multi-cycle unit
- o_mc_tmo  out  1  one-cycle timeout pulse
- o_busy  out  1  state != RUN

## Operation
- States: RUN, MCWAIT, REDIRECT. Default per cycle: o_pc_en=1, o_en=4'b1111, o_srsh=0, o_pc_sel=00, o_mc_kill=0.
- Priority, highest first; the first matching event applies in any state:
  1. i_trap: o_srsh=4'b1111, o_pc_sel=10, o_pc_en=1, next REDIRECT. In MCWAIT, also o_mc_kill=1.
  2. i_dmem_wait: o_pc_en=0, o_en=0, o_srsh=0. State unchanged.
  3. MCWAIT: o_pc_en=0, o_en[1:0]=0, o_srsh[2]=1, o_en[3]=1.
     - i_mc_done: all enabled, no flush, next RUN.
     - i_br_mispred and i_mc_start ignored.
  4. RUN and i_br_mispred: o_srsh[1:0]=2'b11, o_pc_sel=01, next REDIRECT.
  5. RUN and i_mc_start and !i_mc_done: MCWAIT outputs as in item 3, next MCWAIT. With i_mc_done in the same cycle: no stall, stay RUN.
  6. i_load_use (RUN only): o_pc_en=0, o_en[0]=0, o_srsh[1]=1.
  7. i_imem_wait: o_pc_en=0, o_srsh[0]=1. State unchanged.
- REDIRECT: o_srsh[0]=1 to drop the stale fetch, o_pc_en=1, o_pc_sel=00. Next RUN unless i_imem_wait; with i_imem_wait, o_pc_en=0 and stay REDIRECT. Items 1 and 2 still take priority.
- Timeout counter, width $clog2(MC_TMO+1):
  - Clears on entry to MCWAIT and in all other states; increments each MCWAIT cycle, saturating.
  - o_mc_tmo=1 only in the cycle the count reaches MC_TMO. No state change results.
- The register pair is all-or-nothing: an output bit pattern never sets o_srsh[i] where the intent is hold.

## Timing
- Outputs are combinational from state and inputs. State and counter update on the rising edge of i_clk.
- While i_rst=1: state=RUN, counter=0, o_pc_en=0, o_en=0, o_srsh=4'b1111, o_pc_sel=00, o_mc_kill=0, o_mc_tmo=0, o_busy=0.
- Release of i_rst: first edge behaves as RUN with no events.
- Branch redirect costs 2 bubbles: ID/EX+IF/ID flush, then REDIRECT IF/ID flush.
- Trap costs 4 flushed stages plus 1 REDIRECT bubble.
- Load-use costs 1 bubble. Multi-cycle op: EX/MEM receives bubbles from the start cycle until the cycle before done.
- Inputs are assumed held stable by their stages while frozen by i_dmem_wait.
- i_rst asserted mid-MCWAIT: immediate return to RUN. No o_mc_kill is issued; the MC unit shares i_rst.

## Test plan
- Reset: i_rst=1 for 3 cycles → o_en=0000, o_srsh=1111, o_pc_en=0, o_busy=0; after release with idle inputs → o_en=1111, o_srsh=0000, o_pc_en=1.
- Mispredict: i_br_mispred=1 one cycle → o_srsh=0011, o_pc_sel=01; next cycle o_busy=1, o_srsh=0001, o_pc_sel=00; following cycle RUN.
- Multi-cycle op: i_mc_start=1, i_mc_done after 5 cycles → o_pc_en=0, o_en=1000, o_srsh=0100 for cycles 0..4; done cycle o_en=1111; then RUN. Also i_mc_start&i_mc_done in the same cycle → no stall.
- Trap during MCWAIT: enter MCWAIT, assert i_trap at cycle 2 → o_srsh=1111, o_pc_sel=10, o_mc_kill=1, next REDIRECT; with i_dmem_wait also high, the trap still wins.
- Priority: i_dmem_wait+i_br_mispred+i_load_use all high → full freeze (o_en=0, o_srsh=0, o_pc_en=0), state RUN; drop i_dmem_wait → mispredict response.
- Timeout: MC_TMO=4, no i_mc_done → o_mc_tmo single pulse in the 4th MCWAIT cycle, none afterwards, state stays MCWAIT.
